fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decoder.
- Holds the PC and issues word requests to instruction memory over a valid/ready request channel with an in-order, variable-latency response channel.
- Buffers returned words with their addresses in a small FIFO and presents them to the decoder as inst/inst_addr under a valid/ready handshake.
- Accepts a redirect (branch/jump) that flushes the buffer and drops stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, 2..8.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_req_addr  output  32  word address, bits[1:0] always 0.
- imem_rsp_valid  input  1  response word valid; in order, at least 1 cycle after acceptance.
- imem_rsp_data  input  32  instruction word.
- redirect_valid  input  1  one-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  input  32  new PC; bits[1:0] forced to 0.
- inst_valid  output  1  inst/inst_addr valid to the decoder.
- inst_ready  input  1  decoder consumes this cycle.
- inst  output  32  instruction word.
- inst_addr  output  32  address of inst.

Behaviour:
- Reset, asynchronous on rst_n low:
  - pc = RESET_PC; FIFO empty.
  - outstanding = 0; drop_cnt = 0.
  - imem_req_valid = 0, inst_valid = 0, inst = 0, inst_addr = 0.
  - Reset asserted mid-operation discards everything; responses arriving after release that belong to pre-reset requests are the memory's responsibility, and the memory is reset together with this block.
- First request is presented in the first cycle after rst_n is sampled high.
- Credit rule:
  - imem_req_valid = 1 when (fifo_count + outstanding) < FIFO_DEPTH.
  - imem_req_addr = pc.
  - This guarantees that every response has a free FIFO slot, so the response channel has no backpressure.
- Request accepted (imem_req_valid and imem_req_ready): pc += 4, outstanding += 1, and a copy of the address is pushed into an address-tag queue of depth FIFO_DEPTH. PC wraps from 32'hFFFF_FFFC to 0.
- Response handling (imem_rsp_valid):
  - outstanding -= 1 and the address tag is popped.
  - If drop_cnt > 0: drop_cnt -= 1 and the word is discarded.
  - Otherwise {tag, data} is written to the FIFO.
- Output:
  - The FIFO head drives inst/inst_addr registered; inst_valid = FIFO not empty.
  - Latency from response to inst_valid is 1 cycle.
  - Pop on inst_valid and inst_ready.
  - inst/inst_addr hold their value while inst_valid is high and inst_ready is low.
  - While inst_valid is low they hold the last value.
- FIFO full with no pop and no credit: no requests; pc holds.
- Simultaneous push and pop on a full FIFO is legal, and so is push and pop on an empty FIFO. With an empty FIFO the word appears on the next cycle; there is no combinational bypass.
- Redirect, cycle T:
  - A consumer handshake in cycle T completes normally.
  - After T the FIFO is flushed, so inst_valid = 0 at T+1.
  - drop_cnt = outstanding after T's updates, including a request accepted in T and excluding a response consumed in T. A response in cycle T is discarded, since it belongs to the old stream.
  - pc = redirect_pc & ~3 at T+1; the tag queue flushes entries to be dropped logically by count.
  - Requests at T+1 onward use the new pc, subject to the credit rule.
  - Back-to-back redirects: the later one wins; drop_cnt accumulates correctly.
- Invariants:
  - outstanding never exceeds FIFO_DEPTH.
  - drop_cnt <= outstanding.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined:
  - Add output perf_fetched (32 bits): counts words written to the FIFO.
  - Add output perf_stall (32 bits): counts cycles with imem_req_valid = 1 and imem_req_ready = 0.
  - Add output perf_dropped (32 bits): counts discarded responses.
  - All three reset to 0, wrap at 2^32, and do not clear on redirect.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC = 32'h100 -> the first request is at 32'h100 one cycle after release; inst_valid = 0 and inst = 0 during reset.
- Streaming, 1-cycle memory, inst_ready = 1 -> inst_addr sequence 100, 104, 108, 10C on consecutive cycles; inst matches memory contents.
- inst_ready = 0 for 10 cycles -> at most FIFO_DEPTH requests outstanding or buffered, no further requests, and no words lost after inst_ready returns.
- Memory latency 3 with 2 requests in flight, then a redirect to 32'h2002 -> both old responses discarded; the next inst_addr is 32'h2000 and no old-stream words reach inst.
- Redirect in the same cycle as imem_rsp_valid and an inst handshake -> the handshake word is consumed, the response is dropped, and inst_valid = 0 on the next cycle.
- With FETCH_PERF_EN: 5 fetched, 2 stall cycles, 2 dropped in the previous scenario -> perf_fetched = 5, perf_stall = 2, perf_dropped = 2.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage feeding the decoder.
//
// Holds the PC and issues word fetches to instruction memory. Requests are
// credit-limited: a request is only issued when every outstanding response
// is guaranteed a free buffer slot, so the response channel never needs
// backpressure. Returned words are buffered together with their fetch
// address and presented to the decoder under a valid/ready handshake.
// A redirect flushes the buffer and discards responses still in flight
// for the old stream (tracked by a drop counter).
//
// Optional build macro: FETCH_PERF_EN adds three 32-bit performance counters.
//
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   imem_req_valid/ready/addr       fetch request channel (word aligned)
//   imem_rsp_valid/data             in-order response channel, no backpressure
//   redirect_valid/redirect_pc      one-cycle restart pulse and new PC
//   inst_valid/ready, inst,
//   inst_addr                       instruction stream towards the decoder
//   perf_fetched/stall/dropped      (FETCH_PERF_EN only) words buffered,
//                                   request stall cycles, discarded responses
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_addr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_dropped
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [31:0]      pc_reg, pc_next;
    logic             started_reg;
    logic [CNT_W-1:0] out_cnt_reg, out_cnt_next;
    logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;
    logic [CNT_W-1:0] fifo_cnt_reg, fifo_cnt_after_pop;
    logic [PTR_W-1:0] tag_wr_ptr_reg, tag_rd_ptr_reg;
    logic [PTR_W-1:0] fifo_wr_ptr_reg, fifo_rd_ptr_reg, rd_ptr_adv;
    logic [31:0]      tag_mem       [FIFO_DEPTH];
    logic [31:0]      fifo_addr_mem [FIFO_DEPTH];
    logic [31:0]      fifo_data_mem [FIFO_DEPTH];
    logic             inst_valid_reg;
    logic [31:0]      inst_reg, inst_addr_reg;
    logic [31:0]      head_addr_next, head_data_next, rsp_tag;
    logic [CNT_W:0]   credit_sum;
    logic             req_valid, req_fire, pop, push;

    always_comb begin
        // Buffered words plus in-flight requests may never exceed the buffer.
        credit_sum = {1'b0, fifo_cnt_reg} + {1'b0, out_cnt_reg};
        req_valid  = started_reg && (credit_sum < {1'b0, DEPTH_C});
        req_fire   = req_valid && imem_req_ready;
        pop        = inst_valid_reg && inst_ready;
        // A response arriving with a redirect belongs to the old stream.
        push       = imem_rsp_valid && (drop_cnt_reg == '0) && !redirect_valid;
        rsp_tag    = tag_mem[tag_rd_ptr_reg];

        out_cnt_next = out_cnt_reg + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
        // On redirect everything still in flight (after this cycle) is stale.
        if (redirect_valid)
            drop_cnt_next = out_cnt_next;
        else if (imem_rsp_valid && (drop_cnt_reg != '0))
            drop_cnt_next = drop_cnt_reg - CNT_W'(1);
        else
            drop_cnt_next = drop_cnt_reg;

        // Next head of the buffer: the incoming word if the buffer drains,
        // otherwise the stored entry following any pop.
        rd_ptr_adv         = fifo_rd_ptr_reg + PTR_W'(pop);
        fifo_cnt_after_pop = fifo_cnt_reg - CNT_W'(pop);
        if (fifo_cnt_after_pop == '0) begin
            head_addr_next = rsp_tag;
            head_data_next = imem_rsp_data;
        end else begin
            head_addr_next = fifo_addr_mem[rd_ptr_adv];
            head_data_next = fifo_data_mem[rd_ptr_adv];
        end

        if (redirect_valid)
            pc_next = redirect_pc & ~32'h3;
        else if (req_fire)
            pc_next = pc_reg + 32'd4;
        else
            pc_next = pc_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg          <= RESET_PC;
            started_reg     <= 1'b0;
            out_cnt_reg     <= '0;
            drop_cnt_reg    <= '0;
            tag_wr_ptr_reg  <= '0;
            tag_rd_ptr_reg  <= '0;
            fifo_cnt_reg    <= '0;
            fifo_wr_ptr_reg <= '0;
            fifo_rd_ptr_reg <= '0;
            inst_valid_reg  <= 1'b0;
            inst_reg        <= '0;
            inst_addr_reg   <= '0;
        end else begin
            started_reg    <= 1'b1;
            pc_reg         <= pc_next;
            out_cnt_reg    <= out_cnt_next;
            drop_cnt_reg   <= drop_cnt_next;
            tag_wr_ptr_reg <= tag_wr_ptr_reg + PTR_W'(req_fire);
            tag_rd_ptr_reg <= tag_rd_ptr_reg + PTR_W'(imem_rsp_valid);
            if (redirect_valid) begin
                // Flush; inst/inst_addr keep their last value.
                fifo_cnt_reg    <= '0;
                fifo_wr_ptr_reg <= '0;
                fifo_rd_ptr_reg <= '0;
                inst_valid_reg  <= 1'b0;
            end else begin
                fifo_cnt_reg    <= fifo_cnt_after_pop + CNT_W'(push);
                fifo_wr_ptr_reg <= fifo_wr_ptr_reg + PTR_W'(push);
                fifo_rd_ptr_reg <= rd_ptr_adv;
                inst_valid_reg  <= (fifo_cnt_after_pop != '0) || push;
                if ((fifo_cnt_after_pop != '0) || push) begin
                    inst_reg      <= head_data_next;
                    inst_addr_reg <= head_addr_next;
                end
            end
        end
    end

    // Storage arrays carry no reset; pointers and counts define validity.
    always_ff @(posedge clk) begin
        if (req_fire)
            tag_mem[tag_wr_ptr_reg] <= imem_req_addr;
        if (push) begin
            fifo_addr_mem[fifo_wr_ptr_reg] <= rsp_tag;
            fifo_data_mem[fifo_wr_ptr_reg] <= imem_rsp_data;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
            perf_dropped <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(push);
            perf_stall   <= perf_stall + 32'(req_valid && !imem_req_ready);
            perf_dropped <= perf_dropped + 32'(imem_rsp_valid && !push);
        end
    end
`endif

    assign imem_req_valid = req_valid;
    assign imem_req_addr  = pc_reg;
    assign inst_valid     = inst_valid_reg;
    assign inst           = inst_reg;
    assign inst_addr      = inst_addr_reg;

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          STREAM_LEN = 128;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_addr;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall, perf_dropped;
`endif

    fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_addr(inst_addr)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_stall(perf_stall),
        .perf_dropped(perf_dropped)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { int gen; logic [31:0] addr; logic [31:0] data; } exp_t;
    typedef struct { logic [31:0] addr; int due; } req_t;

    exp_t exp_q[$];     // expected instruction stream, tagged by stream number
    req_t mem_q[$];     // memory model: accepted requests awaiting response
    int   acc_gen_q[$]; // stream number of each accepted request

    int checks = 0, fails = 0, cyc = 0;
    int issue_gen = 0, mon_gen = 0;
    int lat_min = 1, lat_max = 1, ready_pct = 100, inst_ready_pct = 100;
    int n_fetched = 0, n_dropped = 0, n_stall = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // New instruction stream starting at pc: consecutive words, wrapping at 2^32.
    task automatic push_stream(input int gen, input logic [31:0] pc);
        exp_t e;
        logic [31:0] a;
        a = pc & ~32'h3;
        for (int i = 0; i < STREAM_LEN; i++) begin
            e.gen = gen; e.addr = a; e.data = mem_word(a);
            exp_q.push_back(e);
            a = a + 32'd4;
        end
    endtask

    // Start one clock cycle and drive all inputs for it.
    task automatic step();
        req_t r;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            r = mem_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(r.addr);
        end
        imem_req_ready = ($urandom_range(99) < ready_pct);
        inst_ready     = ($urandom_range(99) < inst_ready_pct);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        issue_gen++;
        push_stream(issue_gen, pc);
        $display("redirect pc=%h cycle %0d", pc, cyc);
    endtask

    // Memory acceptance, scoreboard and invariant monitor.
    logic        prev_stall = 1'b0, prev_valid = 1'b0, prev_redirect = 1'b0;
    logic [31:0] prev_inst = '0, prev_addr = '0;
    always @(negedge clk) begin
        req_t r;
        exp_t e;
        int   g;
        if (rst_n) begin
            if (imem_req_valid)
                check("req_addr_align", {30'd0, imem_req_addr[1:0]}, 32'd0);
            if (imem_req_valid && imem_req_ready) begin
                r.addr = imem_req_addr;
                r.due  = cyc + int'($urandom_range(lat_max, lat_min));
                mem_q.push_back(r);
                acc_gen_q.push_back(mon_gen);
            end
            if (imem_req_valid && !imem_req_ready) n_stall++;
            if (imem_rsp_valid && acc_gen_q.size() > 0) begin
                g = acc_gen_q.pop_front();
                if (g == mon_gen && !redirect_valid) n_fetched++;
                else n_dropped++;
            end
            check("inflight_bound", 32'(mem_q.size() <= DEPTH), 32'd1);
            if (prev_redirect)
                check("flush_after_redirect", {31'd0, inst_valid}, 32'd0);
            if (prev_stall || (!prev_valid && !inst_valid)) begin
                check("inst_hold", inst, prev_inst);
                check("inst_addr_hold", inst_addr, prev_addr);
            end
            if (inst_valid && inst_ready) begin
                while (exp_q.size() > 0 && exp_q[0].gen < mon_gen) void'(exp_q.pop_front());
                if (exp_q.size() == 0 || exp_q[0].gen != mon_gen) begin
                    check("scoreboard_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    $display("inst addr=%h data=%h cycle %0d", inst_addr, inst, cyc);
                    check("inst_addr", inst_addr, e.addr);
                    check("inst_data", inst, e.data);
                end
            end
            if (redirect_valid) mon_gen++;
            prev_redirect = redirect_valid;
            prev_stall    = inst_valid && !inst_ready;
            prev_valid    = inst_valid;
            prev_inst     = inst;
            prev_addr     = inst_addr;
        end
    end

    initial begin
        int since;
        rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_addr", inst_addr, 32'd0);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        push_stream(0, RST_PC);
        @(posedge clk); #1;
        rst_n = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
        @(negedge clk);
        check("req_before_first_edge", {31'd0, imem_req_valid}, 32'd0);

        // Streaming with a 1-cycle memory: one word per cycle once primed.
        step(); @(negedge clk);
        check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("first_req_addr", imem_req_addr, RST_PC);
        for (int i = 1; i < 12; i++) begin
            step(); @(negedge clk);
            if (i >= 2) check("stream_inst_valid", {31'd0, inst_valid}, 32'd1);
        end

        // Decoder stalls for 10 cycles: buffer fills, requests stop.
        inst_ready_pct = 0;
        repeat (10) step();
        @(negedge clk);
        check("stall_req_stopped", {31'd0, imem_req_valid}, 32'd0);
        check("stall_inst_valid", {31'd0, inst_valid}, 32'd1);
        inst_ready_pct = 100;
        repeat (6) step();

        // Latency-3 memory with requests in flight, then redirect.
        lat_min = 3; lat_max = 3;
        repeat (6) step();
        step(); do_redirect(32'h0000_2002);
        repeat (12) step();

        // Redirect coinciding with a response and a consumer handshake.
        lat_min = 1; lat_max = 1;
        repeat (10) step();
        step(); do_redirect(32'h0000_3000);
        @(negedge clk);
        check("coincide_rsp", {31'd0, imem_rsp_valid}, 32'd1);
        check("coincide_handshake", {31'd0, inst_valid && inst_ready}, 32'd1);
        repeat (8) step();

        // Randomized traffic with back-to-back and wrapping redirects.
        lat_min = 1; lat_max = 4; ready_pct = 70; inst_ready_pct = 70;
        since = 0;
        for (int i = 0; i < 2500; i++) begin
            step();
            since++;
            if ($urandom_range(29) == 0 || since > 80) begin
                if ($urandom_range(3) == 0)
                    do_redirect(32'hFFFF_FFE0 + 32'($urandom_range(31)));
                else
                    do_redirect($urandom);
                since = 0;
            end
        end
        ready_pct = 100; inst_ready_pct = 100;
        repeat (20) step();
        @(negedge clk);
        @(posedge clk); #1;
`ifdef FETCH_PERF_EN
        check("perf_fetched", perf_fetched, 32'(n_fetched));
        check("perf_stall", perf_stall, 32'(n_stall));
        check("perf_dropped", perf_dropped, 32'(n_dropped));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
